pc_predict_unit: RTL and testbench

//  Parametrised fetch-stage PC generator: the successor to the plain PC register/adder pair.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_btb.sv | 85 ++++++++
 rtl/pc_predict_unit.sv | 67 ++++++
 tb/tb_pc_predict_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-stage PC generator and its BTB.
package pc_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
    bp_ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = bp_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) nxt = bp_ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; lookup sees pre-update state.
module pc_btb
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:2] lookup_pc_i,
  output logic            hit_o,
  output logic            ctr_taken_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:2] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i
);

  localparam int unsigned IDXW = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDXW - 2;

  logic            valid_q [BTB_ENTRIES];
  logic            valid_d [BTB_ENTRIES];
  bp_ctr_t         ctr_q   [BTB_ENTRIES];
  bp_ctr_t         ctr_d   [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q   [BTB_ENTRIES];
  logic [TAGW-1:0] tag_d   [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_q   [BTB_ENTRIES];
  logic [XLEN-1:0] tgt_d   [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic [1:0]      lk_ctr;
  logic            up_hit;

  assign lk_idx = lookup_pc_i[IDXW+1:2];
  assign lk_tag = lookup_pc_i[XLEN-1:IDXW+2];
  assign up_idx = upd_pc_i[IDXW+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IDXW+2];

  assign lk_ctr      = ctr_q[lk_idx];
  assign hit_o       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign ctr_taken_o = hit_o && lk_ctr[1];
  assign target_o    = tgt_q[lk_idx];
  assign up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_valid_i) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_next(ctr_q[up_idx], upd_taken_i);
        if (upd_taken_i) tgt_d[up_idx] = upd_target_i;
      end else if (upd_taken_i) begin
        // Allocation simply overwrites whatever alias held this slot.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = upd_target_i;
        ctr_d[up_idx]   = WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target payload is qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with next-PC select: redirect > stall > BTB prediction > PC+4.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     BTB_ENTRIES  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            btb_hit, btb_ctr_taken;
  logic [XLEN-1:0] btb_target;
  logic            unused_bits;

  assign unused_bits = ^{redirect_pc_i[1:0], upd_pc_i[1:0]};

  pc_btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset_n      (reset_n),
    .lookup_pc_i  (pc_q[XLEN-1:2]),
    .hit_o        (btb_hit),
    .ctr_taken_o  (btb_ctr_taken),
    .target_o     (btb_target),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i[XLEN-1:2]),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i)
  );

  assign pc_plus4      = pc_q + XLEN'(INSTR_BYTES);
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign pred_taken_o  = btb_ctr_taken;
  assign pred_target_o = btb_hit ? btb_target : pc_plus4;

  // Low two bits are forced clear on every load so the fetch PC stays word aligned.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect_i)        pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    else if (stall_i)      pc_d = pc_q;
    else if (btb_ctr_taken) pc_d = {btb_target[XLEN-1:2], 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= {RESET_VECTOR[XLEN-1:2], 2'b00};
    else          pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Randomised and directed bench for pc_predict_unit against a table-based BTB model.
module tb_pc_predict_unit;

  localparam logic [31:0] RV = 32'h0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, redirect_i, upd_valid_i, upd_taken_i;
  logic [31:0] redirect_pc_i, upd_pc_i, upd_target_i;
  logic [31:0] pc_o, pc_plus4_o, pred_target_o;
  logic        pred_taken_o;

  int n_chk = 0;
  int n_err = 0;

  // Model: 16-slot table indexed by word address mod 16, tag = address / 64.
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_pc;

  pc_predict_unit #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .BTB_ENTRIES  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_pc = RV;
  endtask

  // Called just after a falling edge; applies inputs for one cycle and checks outputs.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt);
    int          li, ui;
    bit          hit, uhit, pt;
    logic [31:0] p4, ptgt, npc;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utgt;
    #1;
    p4   = m_pc + 32'd4;
    li   = int'((m_pc >> 2) % 16);
    hit  = m_valid[li] && (m_tag[li] == (m_pc >> 6));
    pt   = hit && (m_ctr[li] >= 2);
    ptgt = hit ? m_tgt[li] : p4;
    chk("pc", pc_o, m_pc);
    chk("pc_plus4", pc_plus4_o, p4);
    chk("pred_taken", {31'd0, pred_taken_o}, {31'd0, pt});
    chk("pred_target", pred_target_o, ptgt);
    if (rd)      npc = rpc & ~32'h3;
    else if (st) npc = m_pc;
    else if (pt) npc = ptgt & ~32'h3;
    else         npc = p4;
    @(posedge clk);
    m_pc = npc;
    if (uv) begin
      ui   = int'((upc >> 2) % 16);
      uhit = m_valid[ui] && (m_tag[ui] == (upc >> 6));
      if (uhit) begin
        if (ut) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utgt;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[ui] = 1;
        m_tag[ui]   = upc >> 6;
        m_tgt[ui]   = utgt;
        m_ctr[ui]   = 2;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] a);
    step(0, 1, a, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] a, input bit t, input logic [31:0] tgt);
    step(1, 0, 32'h0, 1, a, t, tgt);
  endtask

  initial begin
    logic [31:0] ra, ua, ut_a;
    reset_n = 1'b0;
    stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    upd_valid_i = 0; upd_pc_i = 0; upd_taken_i = 0; upd_target_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc", pc_o, RV);
    chk("rst_pt", {31'd0, pred_taken_o}, 32'd0);
    reset_n = 1'b1;

    // Free run, then stall at 8.
    idle(); idle();
    chk("run_pc8", pc_o, 32'h8);
    step(1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    chk("stall_hold", pc_o, 32'h8);
    idle();

    // Redirect beats stall, low bits dropped.
    step(1, 1, 32'h103, 0, 32'h0, 0, 32'h0);
    chk("redir_over_stall", pc_o, 32'h100);

    // Train 0x10 -> 0x4.
    upd(32'h10, 1, 32'h4);
    redir(32'h10);
    chk("train_pt", {31'd0, pred_taken_o}, 32'd1);
    chk("train_tgt", pred_target_o, 32'h4);
    idle();
    chk("train_follow", pc_o, 32'h4);
    upd(32'h10, 0, 32'h0);
    upd(32'h10, 0, 32'h0);
    redir(32'h10);
    chk("untrain_pt", {31'd0, pred_taken_o}, 32'd0);
    idle();

    // Saturation: 4 taken then 1 not-taken keeps predicting taken.
    repeat (4) upd(32'h20, 1, 32'h80);
    upd(32'h20, 0, 32'h0);
    redir(32'h20);
    chk("sat_pt", {31'd0, pred_taken_o}, 32'd1);
    idle();

    // Alias: 0x50 evicts 0x10 in slot 4.
    upd(32'h10, 1, 32'h8);
    upd(32'h50, 1, 32'h200);
    redir(32'h10);
    chk("alias_old_pt", {31'd0, pred_taken_o}, 32'd0);
    chk("alias_old_tgt", pred_target_o, 32'h14);
    redir(32'h50);
    chk("alias_new_pt", {31'd0, pred_taken_o}, 32'd1);
    chk("alias_new_tgt", pred_target_o, 32'h200);
    idle();

    // Wrap at the top of the address space.
    redir(32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus4_o, 32'h0);
    idle();
    chk("wrap_pc", pc_o, 32'h0);

    // Reset in mid-cycle with an update in flight.
    redir(32'h50);
    stall_i = 1; upd_valid_i = 1; upd_pc_i = 32'h30; upd_taken_i = 1; upd_target_i = 32'h40;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_pc", pc_o, RV);
    chk("midrst_pt", {31'd0, pred_taken_o}, 32'd0);
    @(negedge clk);
    model_reset();
    reset_n = 1'b1;
    redir(32'h50);
    redir(32'h20);
    redir(32'h30);
    idle();

    // Random traffic confined to a few aliasing regions so hits are common.
    for (int n = 0; n < 500; n++) begin
      ra   = ($urandom_range(0, 15) << 2) + ($urandom_range(0, 3) << 6) + $urandom_range(0, 3);
      ua   = ($urandom_range(0, 15) << 2) + ($urandom_range(0, 3) << 6);
      ut_a = ($urandom_range(0, 15) << 2) + ($urandom_range(0, 3) << 6);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, ra,
           $urandom_range(0, 1) == 1, ua, $urandom_range(0, 2) != 0, ut_a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
